// File: rtl/inv_freq_meter_pkg.sv
// inv_meas_pkg: shared types and defaults for the inverter-chain frequency meter.
//   meas_state_e    : measurement FSM state encoding
//   gate_w()        : gate-counter width for a given window length
//   *_DEF           : default parameter values for inv_freq_meter
package inv_meas_pkg;

    localparam int GATE_CYCLES_DEF = 1000;
    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } meas_state_e;

    // The gate counter only ever holds GATE_CYCLES-1 down to 0,
    // so clog2(GATE_CYCLES) bits are enough.
    function automatic int gate_w(input int gate_cycles);
        return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/inv_freq_meter_if.sv
// inv_freq_meter_if: control/result bundle of the frequency meter.
//   start, abort            : requester -> meter
//   busy, valid, count,
//   overflow, stuck         : meter -> requester
// master = requester side, slave = meter side.
interface inv_freq_meter_if #(
    parameter int CNT_W = inv_meas_pkg::CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             stuck;

    modport master (
        output start, abort,
        input  busy, valid, count, overflow, stuck
    );

    modport slave (
        input  start, abort,
        output busy, valid, count, overflow, stuck
    );
endinterface

// File: rtl/inv_freq_meter_sync_edge_det.sv
// sync_edge_det: brings an asynchronous input into the clk domain and flags
// its rising edges.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears the whole chain
//   d     : asynchronous input (inverter-ring output)
//   rise  : one-cycle pulse per synchronized rising edge
module sync_edge_det
    import inv_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/inv_freq_meter.sv
// inv_freq_meter: counts rising edges of a free-running inverter-ring output
// over a fixed window of GATE_CYCLES clocks and reports the result with a
// one-cycle valid pulse.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   osc_in  : ring output, asynchronous to clk
//   bus     : start/abort in; busy/valid/count/overflow/stuck out
// Build option: INV_FREQ_METER_STUCK_DETECT_EN enables the zero-edge (stuck)
// flag; without it stuck is tied low.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | clear edge counter, load gate counter (1 cycle)
// MEAS  | count rises until gate counter reaches 0
// DONE  | results visible, valid high (1 cycle)
module inv_freq_meter
    import inv_meas_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               osc_in,
    inv_freq_meter_if.slave    bus
);

    localparam int                GATE_W    = gate_w(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    meas_state_e       state_q, state_nxt;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  edge_q, edge_nxt;
    logic              ovf_q, ovf_nxt;
    logic              rise;
    logic              load_result;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (osc_in),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // abort outranks gate expiry in MEAS; in IDLE only start is looked at.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (bus.start) state_nxt = ARM;
            ARM:  state_nxt = bus.abort ? IDLE : MEAS;
            MEAS: begin
                if (bus.abort)          state_nxt = IDLE;
                else if (gate_q == '0)  state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == ARM) || (state_q == MEAS);
        bus.valid = (state_q == DONE);
    end

    // Saturating edge count; a rise that finds the counter full marks overflow.
    always_comb begin
        edge_nxt = edge_q;
        ovf_nxt  = ovf_q;
        if ((state_q == MEAS) && rise) begin
            if (edge_q == CNT_MAX) ovf_nxt  = 1'b1;
            else                   edge_nxt = edge_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= '0;
            edge_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    gate_q <= GATE_LOAD;
                    edge_q <= '0;
                    ovf_q  <= 1'b0;
                end
                MEAS: begin
                    if (gate_q != '0) gate_q <= gate_q - 1'b1;
                    edge_q <= edge_nxt;
                    ovf_q  <= ovf_nxt;
                end
                default: ;
            endcase
        end
    end

    // Results are captured on the edge that enters DONE so they line up with
    // valid; the rise seen in the final MEAS cycle is included via edge_nxt.
    assign load_result = (state_q == MEAS) && (state_nxt == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (load_result) begin
            count_q    <= edge_nxt;
            overflow_q <= ovf_nxt;
        end
    end

    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

`ifdef INV_FREQ_METER_STUCK_DETECT_EN
    logic stuck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           stuck_q <= 1'b0;
        else if (load_result) stuck_q <= (edge_nxt == '0);
    end

    assign bus.stuck = stuck_q;
`else
    assign bus.stuck = 1'b0;
`endif

endmodule

// File: tb/tb_inv_freq_meter.sv
// Two meters (CNT_W=8 and CNT_W=2, both GATE_CYCLES=16) share clock, reset,
// oscillator and control. Each accepted start pushes the expected rise count
// to a scoreboard; it is popped in the cycle valid is due and turned into the
// held count/overflow/stuck expectations for both widths.
module tb_inv_freq_meter;

    localparam int G = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic osc   = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    inv_freq_meter_if #(.CNT_W(8)) bus_a ();
    inv_freq_meter_if #(.CNT_W(2)) bus_s ();

    assign bus_a.start = start;
    assign bus_a.abort = abort;
    assign bus_s.start = start;
    assign bus_s.abort = abort;

    inv_freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .osc_in (osc), .bus (bus_a)
    );

    inv_freq_meter #(.GATE_CYCLES(G), .CNT_W(2), .SYNC_STAGES(2)) dut_s (
        .clk (clk), .rst_n (rst_n), .osc_in (osc), .bus (bus_s)
    );

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Oscillator: mode 0 held low, mode 1 period 4 clk, mode 2 period 2 clk.
    int osc_mode = 0;
    int ph       = 0;
    always @(posedge clk) begin
        #2;
        ph++;
        case (osc_mode)
            1:       if (ph % 2 == 0) osc = ~osc;
            2:       osc = ~osc;
            default: osc = 1'b0;
        endcase
    end

    function automatic int rises_for(input int mode);
        return (mode == 1) ? G / 4 : (mode == 2) ? G / 2 : 0;
    endfunction

    int sb_q[$];
    int busy_from = -1;
    int busy_to   = -2;
    int valid_at  = -1;
    int exp_cnt_a = 0, exp_ovf_a = 0, exp_cnt_s = 0, exp_ovf_s = 0, exp_stuck = 0;

    // Monitor: cyc = number of posedges so far; outputs sampled 1 time unit
    // after the edge.
    always @(posedge clk) begin
        int n;
        cyc++;
        #1;
        if (valid_at == cyc) begin
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                n         = sb_q.pop_front();
                exp_cnt_a = (n > 255) ? 255 : n;
                exp_ovf_a = (n > 255) ? 1 : 0;
                exp_cnt_s = (n > 3) ? 3 : n;
                exp_ovf_s = (n > 3) ? 1 : 0;
`ifdef INV_FREQ_METER_STUCK_DETECT_EN
                exp_stuck = (n == 0) ? 1 : 0;
`else
                exp_stuck = 0;
`endif
            end
        end
        chk("valid_a", bus_a.valid, (valid_at == cyc) ? 1 : 0);
        chk("valid_s", bus_s.valid, (valid_at == cyc) ? 1 : 0);
        chk("busy_a",  bus_a.busy,  (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
        chk("busy_s",  bus_s.busy,  (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
        chk("count_a", bus_a.count, exp_cnt_a);
        chk("ovf_a",   bus_a.overflow, exp_ovf_a);
        chk("count_s", bus_s.count, exp_cnt_s);
        chk("ovf_s",   bus_s.overflow, exp_ovf_s);
        chk("stuck_a", bus_a.stuck, exp_stuck);
        chk("stuck_s", bus_s.stuck, exp_stuck);
    end

    // All driver tasks are entered on a negedge; the start edge is cyc+1,
    // ARM is cycle T, MEAS T+1..T+G, DONE (valid) T+G+1, which is captured
    // by edge T+G+2 (18 edges after the start edge for G=16).
    task automatic go(input int n_rise, input bit with_abort);
        start     = 1'b1;
        abort     = with_abort;
        busy_from = cyc + 1;
        busy_to   = cyc + 1 + G;
        valid_at  = cyc + 2 + G;
        sb_q.push_back(n_rise);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic stray_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort    = 1'b1;
        busy_to  = cyc;
        valid_at = -1;
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    int t0;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",  bus_a.busy,  0);
        chk("rst_valid", bus_a.valid, 0);
        chk("rst_count", bus_a.count, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // period-4 input: 4 rises; narrow meter saturates at 3
        osc_mode = 1; idle(6);
        go(rises_for(1), 1'b0); idle(20);

        // period-2 input: 8 rises
        osc_mode = 2; idle(6);
        go(rises_for(2), 1'b0); idle(20);

        // no edges in the window
        osc_mode = 0; idle(6);
        go(rises_for(0), 1'b0); idle(20);

        // start in MEAS cycle 5 and in DONE ignored, then back-to-back start
        osc_mode = 1; idle(6);
        go(rises_for(1), 1'b0);
        t0 = busy_from;
        wait_to(t0 + 5);
        stray_start();
        wait_to(valid_at);
        stray_start();
        go(rises_for(1), 1'b0);
        idle(20);

        // abort at MEAS cycle 8: results keep the previous window
        go(rises_for(1), 1'b0);
        t0 = busy_from;
        wait_to(t0 + 8);
        do_abort();
        idle(25);

        // abort in the last MEAS cycle wins over gate expiry
        go(rises_for(1), 1'b0);
        t0 = busy_from;
        wait_to(t0 + G);
        do_abort();
        idle(25);

        // start and abort together in IDLE: start wins
        go(rises_for(1), 1'b1); idle(20);

        // reset at MEAS cycle 6
        osc_mode = 2; idle(6);
        go(rises_for(2), 1'b0);
        t0 = busy_from;
        wait_to(t0 + 6);
        valid_at  = -1;
        busy_to   = -2;
        sb_q.delete();
        exp_cnt_a = 0; exp_ovf_a = 0; exp_cnt_s = 0; exp_ovf_s = 0; exp_stuck = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  bus_a.busy,     0);
        chk("arst_count", bus_a.count,    0);
        chk("arst_ovf_s", bus_s.overflow, 0);
        idle(3);
        rst_n = 1'b1;
        idle(25);
        go(rises_for(2), 1'b0); idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_freq_meter.md
Name: inv_freq_meter

Overview:
- Downstream consumer of the CMOS inverter / inverter-chain stage.
- Takes the free-running output of an inverter ring (`osc_in`), which is asynchronous to `clk`, and synchronizes it.
- Counts its rising edges over a fixed gate window of `GATE_CYCLES` clock cycles and reports the count with a valid pulse.
- Used to characterize inverter-chain delay in simulation and on the bench.

Parameters:
- GATE_CYCLES, 1000: measurement window length in clk cycles; legal range 2 to 2^24-1.
- CNT_W, 16: edge-count width; the counter saturates at 2^CNT_W-1.
- SYNC_STAGES, 2: synchronizer depth on osc_in; minimum 2.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- osc_in  input  1  inverter-chain output; asynchronous to clk.
- start  input  1  one-cycle request to begin a measurement.
- abort  input  1  cancels an in-progress measurement.
- busy  output  1  high while a measurement is in progress.
- valid  output  1  one-cycle pulse when count is updated.
- count  output  CNT_W  rising-edge count of the last completed window.
- overflow  output  1  last completed window saturated the counter.
- stuck  output  1  last completed window saw zero edges (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): every flop clears.
  - State goes to IDLE.
  - busy=0, valid=0, count=0, overflow=0, stuck=0.
  - Synchronizer and edge-detect history clear to 0.
  - Reset asserted mid-measurement discards the window and produces no valid.
- Front end:
  - osc_in passes through SYNC_STAGES flops; a prev flop holds the last synchronized value.
  - rise = sync & ~prev, one cycle per rising edge.
  - The front end runs continuously in every state.
- FSM, states IDLE, ARM, MEAS, DONE:
  - IDLE: start=1 -> ARM.
  - ARM (1 cycle): edge counter cleared, gate counter loaded with GATE_CYCLES-1, busy=1 -> MEAS.
  - MEAS: rise increments the edge counter. The counter saturates at all-ones; a rise at saturation sets an internal ovf flag. The gate counter decrements each cycle; when it reaches 0 (after exactly GATE_CYCLES MEAS cycles) -> DONE.
  - DONE (1 cycle): count, overflow and stuck are updated from the internal registers; valid=1; busy=0 -> IDLE.
- Latency: start sampled at edge T; ARM covers T+1; MEAS covers T+2 .. T+1+GATE_CYCLES; valid is high in cycle T+2+GATE_CYCLES.
- Only rise pulses in MEAS cycles are counted. Edges in ARM, DONE or IDLE are ignored.
- start while busy=1 or in DONE is ignored (no queueing).
- abort in ARM or MEAS -> IDLE next cycle. busy drops, no valid, and count/overflow/stuck keep their previous values.
- abort and start in the same cycle while in IDLE: start wins.
- abort has priority over gate expiry in the same cycle.
- count, overflow and stuck hold their values until the next DONE.
- valid is never high for two consecutive cycles.

Optional Feature:
- Macro: INV_FREQ_METER_STUCK_DETECT_EN.
- Defined: in DONE, stuck = (edge counter == 0). stuck holds until the next DONE.
- Not defined: stuck is tied to 0 and no comparison logic is built.
- The port list is identical in both builds.

Decomposition:
- Package inv_meas_pkg holds:
  - the state enum type (IDLE, ARM, MEAS, DONE);
  - the GATE_W width function (clog2 of GATE_CYCLES);
  - the localparam default values.
- Sub-module sync_edge_det(clk, rst_n, d, rise), parameterized by SYNC_STAGES, contains the synchronizer chain plus the prev flop.
- The FSM, gate counter and edge counter live in the top module.

Test Plan:
- Period-4 case (GATE_CYCLES=16, CNT_W=8): osc_in period 4 clk, start pulse -> valid exactly 18 cycles after the start edge, count=4, overflow=0, stuck=0.
- Saturation (CNT_W=2, GATE_CYCLES=16): osc_in toggling every clk (period 2) -> count=3, overflow=1, valid single cycle.
- Stuck input (macro defined): osc_in held 0 for the whole window -> count=0, stuck=1. Rebuilt without the macro, the same stimulus -> stuck=0.
- Start while busy (GATE_CYCLES=16): start re-pulsed at MEAS cycle 5 -> ignored, single valid at cycle 18. Then start immediately after valid -> a new measurement begins.
- Abort: measure once (count=4), start again, abort at MEAS cycle 8 -> busy=0 next cycle, no valid, count still 4.
- Reset mid-measurement: rst_n low at MEAS cycle 6 -> all outputs 0 asynchronously. After release, no valid until a new start.
